// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronize, debounce, reject overlapping coins,
// and buffer one qualified coin while the vending FSM is busy.
module coin_acceptor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_n,
  input  logic       raw_d,
  input  logic       raw_q,
  input  logic       busy,
  output logic       N,
  output logic       D,
  output logic       Q,
  output logic       REJ,
  output logic       pending,
  output logic [7:0] rej_count
);

  typedef enum logic [1:0] {
    IDLE,
    QUAL,
    RELEASE
  } state_e;

  localparam logic [7:0] DB = DEBOUNCE_CYCLES[7:0];

  // Bit order {q, d, n}; a coin id is the bit index.
  logic [2:0] sync1_q, sync2_q, s;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] id_q, id_d;
  logic       qual_q, qual_d;
  logic       frej_q, frej_d;
  logic [2:0] lat_mask, others;
  logic       lat;

  logic [2:0] out_q, out_d;
  logic       rej_q, rej_d;
  logic       pend_q, pend_d;
  logic [1:0] pid_q, pid_d;
  logic [7:0] rcnt_q, rcnt_d;

  assign s        = sync2_q;
  assign lat_mask = 3'b001 << id_q;
  assign lat      = |(s & lat_mask);
  assign others   = s & ~lat_mask;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= RELEASE;
      cnt_q   <= '0;
      id_q    <= '0;
      qual_q  <= 1'b0;
      frej_q  <= 1'b0;
    end else begin
      sync1_q <= {raw_q, raw_d, raw_n};
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      qual_q  <= qual_d;
      frej_q  <= frej_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    qual_d  = 1'b0;
    frej_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ($onehot(s)) begin
          id_d    = s[0] ? 2'd0 : (s[1] ? 2'd1 : 2'd2);
          cnt_d   = 8'd1;
          state_d = QUAL;
        end else if (s != 3'b000) begin
          frej_d  = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end
      end
      QUAL: begin
        if (others != 3'b000) begin
          frej_d  = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (!lat) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q + 8'd1 == DB) begin
          qual_d  = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RELEASE: begin
        // A line stuck high keeps us here, so it yields one event only.
        if (s != 3'b000) begin
          cnt_d = '0;
        end else if (cnt_q + 8'd1 == DB) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RELEASE;
      end
    endcase
  end

  always_comb begin
    out_d  = 3'b000;
    rej_d  = frej_q;
    pend_d = pend_q;
    pid_d  = pid_q;
    if (!busy && pend_q) begin
      out_d = 3'b001 << pid_q;
      if (qual_q) pid_d = id_q;
      else        pend_d = 1'b0;
    end else if (!busy && qual_q) begin
      out_d = 3'b001 << id_q;
    end else if (busy && !pend_q && qual_q) begin
      pend_d = 1'b1;
      pid_d  = id_q;
    end else if (busy && pend_q && qual_q) begin
      rej_d = 1'b1;
    end
    rcnt_d = (rej_d && rcnt_q != 8'hFF) ? rcnt_q + 8'd1 : rcnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q  <= '0;
      rej_q  <= 1'b0;
      pend_q <= 1'b0;
      pid_q  <= '0;
      rcnt_q <= '0;
    end else begin
      out_q  <= out_d;
      rej_q  <= rej_d;
      pend_q <= pend_d;
      pid_q  <= pid_d;
      rcnt_q <= rcnt_d;
    end
  end

  assign N         = out_q[0];
  assign D         = out_q[1];
  assign Q         = out_q[2];
  assign REJ       = rej_q;
  assign pending   = pend_q;
  assign rej_count = rcnt_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with a pulse scoreboard keyed by
// the expected output cycle.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       raw_n = 1'b0, raw_d = 1'b0, raw_q = 1'b0;
  logic       busy = 1'b0;
  logic       N, D, Q, REJ, pending;
  logic [7:0] rej_count;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic busy_s = 1'b0;

  typedef struct {
    logic [3:0] p;
    int         c;
  } exp_t;
  exp_t sb[$];

  localparam logic [3:0] PN = 4'b0001;
  localparam logic [3:0] PD = 4'b0010;
  localparam logic [3:0] PQ = 4'b0100;
  localparam logic [3:0] PR = 4'b1000;

  coin_acceptor #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .reset(reset),
    .raw_n(raw_n),
    .raw_d(raw_d),
    .raw_q(raw_q),
    .busy(busy),
    .N(N),
    .D(D),
    .Q(Q),
    .REJ(REJ),
    .pending(pending),
    .rej_count(rej_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_s <= busy;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(logic [3:0] p, int c);
    exp_t e;
    e.p = p;
    e.c = c;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    logic [3:0] obs;
    exp_t       e;
    if (mon_en) begin
      obs = {REJ, Q, D, N};
      chk("onehot", 32'($countones({N, D, Q}) <= 1), 32'd1);
      chk("busy_gate", 32'(busy_s & (N | D | Q)), 32'd0);
      if (obs !== 4'b0000) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'(obs), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", 32'(obs), 32'(e.p));
          chk("pulse_cycle", cyc, e.c);
        end
      end
    end
  end

  initial begin
    tick(3);
    mon_en = 1'b1;
    chk("rst_outs", 32'({N, D, Q, REJ, pending}), 32'd0);
    chk("rst_rej_count", 32'(rej_count), 32'd0);
    reset = 1'b1;
    tick(8);

    // single dime
    push(PD, cyc + 7);
    raw_d = 1'b1;
    tick(10);
    raw_d = 1'b0;
    tick(10);
    chk("drain_dime", sb.size(), 0);

    // short nickel glitch
    raw_n = 1'b1;
    tick(2);
    raw_n = 1'b0;
    tick(10);

    // bouncing quarter then steady
    for (int i = 0; i < 6; i++) begin
      raw_q = ~raw_q;
      tick(1);
    end
    push(PQ, cyc + 7);
    raw_q = 1'b1;
    tick(10);
    raw_q = 1'b0;
    tick(10);
    chk("drain_bounce", sb.size(), 0);

    // simultaneous nickel + quarter
    push(PR, cyc + 4);
    raw_n = 1'b1;
    raw_q = 1'b1;
    tick(6);
    raw_n = 1'b0;
    raw_q = 1'b0;
    tick(10);
    chk("simul_rej_count", 32'(rej_count), 32'd1);
    chk("drain_simul", sb.size(), 0);

    // busy buffering
    busy = 1'b1;
    tick(1);
    raw_d = 1'b1;
    tick(10);
    raw_d = 1'b0;
    chk("busy_pending_set", 32'(pending), 32'd1);
    tick(10);
    push(PR, cyc + 7);
    raw_q = 1'b1;
    tick(10);
    raw_q = 1'b0;
    chk("busy_pending_kept", 32'(pending), 32'd1);
    tick(10);
    chk("busy_rej_count", 32'(rej_count), 32'd2);
    push(PD, cyc + 1);
    busy = 1'b0;
    tick(2);
    chk("busy_pending_clr", 32'(pending), 32'd0);
    tick(10);
    chk("drain_busy", sb.size(), 0);

    // reset mid-QUAL with the line held high through release
    raw_n = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    chk("rstq_pending", 32'(pending), 32'd0);
    chk("rstq_rej_count", 32'(rej_count), 32'd0);
    tick(12);
    raw_n = 1'b0;
    tick(8);
    push(PN, cyc + 7);
    raw_n = 1'b1;
    tick(10);
    raw_n = 1'b0;
    tick(10);
    chk("drain_rstq", sb.size(), 0);

    // reset while a coin is buffered
    busy = 1'b1;
    raw_d = 1'b1;
    tick(10);
    raw_d = 1'b0;
    tick(2);
    chk("rstp_pending_set", 32'(pending), 32'd1);
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    busy = 1'b0;
    chk("rstp_pending_clr", 32'(pending), 32'd0);
    chk("rstp_rej_count", 32'(rej_count), 32'd0);
    tick(10);
    chk("drain_rstp", sb.size(), 0);

    // reject counter saturation
    for (int i = 0; i < 260; i++) begin
      push(PR, cyc + 4);
      raw_n = 1'b1;
      raw_q = 1'b1;
      tick(3);
      raw_n = 1'b0;
      raw_q = 1'b0;
      tick(8);
      if (i == 253) chk("rej_count_254", 32'(rej_count), 32'd254);
      if (i == 254) chk("rej_count_255", 32'(rej_count), 32'd255);
    end
    chk("rej_count_hold", 32'(rej_count), 32'd255);
    chk("drain_sat", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end coin qualification stage that sits directly upstream of the vending FSM and generates its N, D and Q inputs. It synchronizes the three raw, bouncy coin-sensor lines and debounces them, and it rejects simultaneous or overlapping coins. When the vending FSM reports busy (dispensing or returning change), it holds one qualified coin in a single-entry buffer. Output is at most one single-cycle coin pulse per physical coin.

## Interface

- DEBOUNCE_CYCLES, 4: consecutive stable samples needed to qualify a coin or a release. Legal range 2..255.
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- raw_n  input  1  asynchronous nickel sensor, active high.
- raw_d  input  1  asynchronous dime sensor, active high.
- raw_q  input  1  asynchronous quarter sensor, active high.
- busy  input  1  high while the vending FSM cannot accept coins (state >= GOT_30c).
- N  output  1  one-cycle nickel pulse.
- D  output  1  one-cycle dime pulse.
- Q  output  1  one-cycle quarter pulse.
- REJ  output  1  one-cycle pulse: coin discarded.
- pending  output  1  the one-entry hold buffer is occupied.
- rej_count  output  8  count of REJ pulses, saturating at 255.

## Operation

- **Synchronizer:** each raw line passes through 2 flops, giving s_n, s_d and s_q. Only the synchronized lines are used downstream.
- **Qualifier FSM states:** IDLE, QUAL and RELEASE. It has one 8-bit counter cnt and a 2-bit latched coin id.
- **IDLE:**
  - All s_* low: stay in IDLE.
  - Exactly one s_* high: latch its id, cnt <= 1, go to QUAL.
  - Two or more high: issue a reject event, cnt <= 0, go to RELEASE.
- **QUAL:**
  - Latched line high and the others low: cnt++.
  - When the incremented cnt would equal DEBOUNCE_CYCLES, raise a qualified event for the latched id, cnt <= 0, go to RELEASE.
  - Latched line drops before qualifying: treat as a glitch. No event, go to IDLE.
  - Any other line rises: issue a reject event, cnt <= 0, go to RELEASE.
- **RELEASE:**
  - All s_* low: cnt++. Reaching DEBOUNCE_CYCLES returns to IDLE.
  - Any line high: cnt <= 0.
  - The effect is that a coin held high (stuck) produces exactly one event.
- **Dispatch stage.** Evaluated every cycle in priority order; all outputs are registered.
  1. busy=0 and pending=1: emit the buffered coin. The buffer takes the new qualified event if one exists this cycle, otherwise it empties.
  2. busy=0, pending=0, qualified event: emit the new coin directly.
  3. busy=1, pending=0, qualified event: store the coin, pending <= 1.
  4. busy=1, pending=1, qualified event: reject the new coin. The buffered coin is kept.
- **Reject events:**
  - Reject events from the FSM and from dispatch case 4 both produce REJ.
  - The FSM and dispatch cannot both reject in the same cycle. If they ever coincide, exactly one REJ pulse is issued and rej_count is incremented once.
- **Output invariants:**
  - At most one of N, D or Q is high in any cycle.
  - N, D and Q are never asserted in a cycle where the registered busy input was high.
- **rej_count:** increments on every REJ pulse and holds at 255.
- **Reset (synchronous, reset=0 at a posedge):**
  - Sync flops <= 0.
  - FSM <= RELEASE, cnt <= 0.
  - N, D, Q and REJ <= 0; pending <= 0 (the buffered coin is dropped); rej_count <= 0.
  - Reset asserted mid-QUAL or mid-RELEASE aborts the coin with no pulse.
  - A sensor stuck high across reset is never counted.

## Timing

- Let edge t0 be the first posedge that samples raw_x high, with busy=0 and the FSM in IDLE.
  - s_x is high after t0+1, and the FSM enters QUAL at t0+2.
  - The qualified event occurs at edge t0+DEBOUNCE_CYCLES+1.
  - The output pulse is high for exactly one cycle following edge t0+DEBOUNCE_CYCLES+2. With the default of 4, the pulse follows edge t0+6.
- Minimum raw high width to qualify: DEBOUNCE_CYCLES cycles. Shorter pulses produce nothing.
- Minimum low gap between coins: DEBOUNCE_CYCLES cycles after the line drops, plus 2 synchronizer cycles.
- Buffered coin: emitted in the cycle following the first edge that samples busy=0.
- REJ: one cycle wide, registered in the same manner as the coin pulses.

## Test plan

- **Single coin:** after reset and DEBOUNCE_CYCLES idle cycles, raw_d high for 10 cycles with busy=0. Required: one D pulse, high during the cycle after edge t0+6; N, Q and REJ stay 0.
- **Glitch and bounce:**
  - raw_n high for 2 cycles: no pulse.
  - raw_q toggling every cycle, then steady for 10 cycles: exactly one Q pulse.
- **Simultaneous coins:** raw_n and raw_q rise on the same edge. Required: one REJ pulse, rej_count=1, no N or Q pulse.
- **Busy buffering:**
  - busy=1, insert a dime: pending=1, no D pulse.
  - Insert a quarter while still busy: REJ pulse, rej_count increments, pending stays 1.
  - Drop busy: D pulse on the next cycle, pending=0, and the quarter is never emitted.
- **Reset mid-operation:** assert reset while in QUAL, and separately while pending=1. Required: no coin pulse, pending=0, rej_count=0. A raw line held high through reset release produces no pulse until it goes low for DEBOUNCE_CYCLES and then rises again.
- **Saturation:** 260 simultaneous-coin rejects. Required: rej_count reads 255 and holds.
